// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants used by the fetch front end.
// Widths, the PC step and the counter-width helper live here.
package riscv_pkg;

    localparam int XLEN_DEF = 32;
    localparam int INSTR_W  = 32;
    localparam int PC_STEP  = 4;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Fetch unit bus bundle: imem request/response, redirects, decode handoff.
// master = fetch unit side, slave = memory/decode environment side.
interface fetch_queue_unit_if
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
);

    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [XLEN-1:0]    imem_req_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               redir_e_valid;
    logic [XLEN-1:0]    redir_e_pc;
    logic               redir_d_valid;
    logic [XLEN-1:0]    redir_d_pc;
    logic               dec_valid;
    logic               dec_ready;
    logic [INSTR_W-1:0] dec_instr;
    logic [XLEN-1:0]    dec_pc;
    logic [XLEN-1:0]    dec_pc_plus4;

    modport master (
        output imem_req_valid, imem_req_addr,
        output dec_valid, dec_instr, dec_pc, dec_pc_plus4,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redir_e_valid, redir_e_pc,
        input  redir_d_valid, redir_d_pc,
        input  dec_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        input  dec_valid, dec_instr, dec_pc, dec_pc_plus4,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redir_e_valid, redir_e_pc,
        output redir_d_valid, redir_d_pc,
        output dec_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with clear; head is visible combinationally.
// Push on full and pop on empty are ignored.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [W-1:0]                 din_i,
    output logic [W-1:0]                 head_o,
    output logic [cnt_w(DEPTH)-1:0]      count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign do_push = push_i && (cnt_q != CW'(DEPTH));
    assign do_pop  = pop_i && (cnt_q != '0);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr_i) mem_q[wr_q] <= din_i;
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/fetch_queue_unit.sv
// IF stage: PC generator, credit-limited imem requests and a fetch queue.
// Redirects flush the queue; stale in-flight responses are dropped by count.
module fetch_queue_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              FQ_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    fetch_queue_unit_if.master fq
);

    localparam int CW = cnt_w(FQ_DEPTH);
    localparam int EW = INSTR_W + XLEN;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   out_q, out_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   occ, tag_cnt;
    logic [CW:0]     credit;
    logic [XLEN-1:0] tgt, tag, head_pc;
    logic [EW-1:0]   head;
    logic            flush, req_valid, req_fire;
    logic            rsp_fire, push, pop, dec_v;

    assign flush = fq.redir_e_valid | fq.redir_d_valid;
    assign tgt   = fq.redir_e_valid ? fq.redir_e_pc : fq.redir_d_pc;

    // Queued entries plus in-flight requests never exceed the queue size.
    assign credit    = {1'b0, occ} + {1'b0, out_q};
    assign req_valid = !rst && !flush && (credit < (CW+1)'(FQ_DEPTH));
    assign req_fire  = req_valid && fq.imem_req_ready;

    assign rsp_fire = fq.imem_rsp_valid && (tag_cnt != '0);
    assign push     = rsp_fire && (drop_q == '0) && !flush;
    assign dec_v    = !rst && (occ != '0);
    assign pop      = dec_v && fq.dec_ready;

    fetch_fifo #(
        .W     (EW),
        .DEPTH (FQ_DEPTH)
    ) u_iq (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (flush),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   ({fq.imem_rsp_data, tag}),
        .head_o  (head),
        .count_o (occ)
    );

    // Never cleared: stale tags retire alongside their dropped responses.
    fetch_fifo #(
        .W     (XLEN),
        .DEPTH (FQ_DEPTH)
    ) u_aq (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (1'b0),
        .push_i  (req_fire),
        .pop_i   (rsp_fire),
        .din_i   (pc_q),
        .head_o  (tag),
        .count_o (tag_cnt)
    );

    always_comb begin
        pc_d   = pc_q;
        out_d  = out_q + CW'(req_fire) - CW'(rsp_fire);
        drop_d = drop_q;
        if (flush) begin
            pc_d   = tgt & ~XLEN'(3);
            drop_d = out_q - CW'(rsp_fire);
        end else begin
            if (req_fire) pc_d = pc_q + XLEN'(PC_STEP);
            if (rsp_fire && drop_q != '0) drop_d = drop_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            out_q  <= '0;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            out_q  <= out_d;
            drop_q <= drop_d;
        end
    end

    assign head_pc = head[XLEN-1:0];

    assign fq.imem_req_valid = req_valid;
    assign fq.imem_req_addr  = req_valid ? pc_q : '0;
    assign fq.dec_valid      = dec_v;
    assign fq.dec_instr      = dec_v ? head[EW-1:XLEN] : '0;
    assign fq.dec_pc         = dec_v ? head_pc : '0;
    assign fq.dec_pc_plus4   = dec_v ? head_pc + XLEN'(PC_STEP) : '0;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: vector table, imem model and scoreboard.
// A second instance covers a reset PC that wraps the address space.
module tb_fetch_queue_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_w = 1'b1;

    always #5 clk = ~clk;

    fetch_queue_unit_if #(.XLEN(32)) f();
    fetch_queue_unit_if #(.XLEN(32)) fw();

    fetch_queue_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0),
        .FQ_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .fq  (f)
    );

    fetch_queue_unit #(
        .XLEN     (32),
        .RESET_PC (32'hFFFF_FFF8),
        .FQ_DEPTH (4)
    ) dut_wrap (
        .clk (clk),
        .rst (rst_w),
        .fq  (fw)
    );

    typedef struct {
        bit          rdy;
        bit          rv;
        logic [31:0] rd;
        bit          re;
        logic [31:0] epc;
        bit          rdv;
        logic [31:0] dpc;
        bit          drdy;
        bit          e_rv;
        logic [31:0] e_ra;
        bit          e_dv;
        logic [31:0] e_pc;
        logic [31:0] e_in;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] epc;
        int          due;
        int          epoch;
    } memreq_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    localparam int NV = 20;

    int          checks = 0;
    int          failures = 0;
    vec_t        tv [NV];
    memreq_t     mq [$];
    exp_t        sbq [$];
    int          cyc, epoch, last_due, first_dv, n_dv_pop;
    logic [31:0] mpc;

    function automatic logic [31:0] mk(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_0013;
    endfunction

    function automatic vec_t v(
        input bit rdy, input bit rv, input logic [31:0] rd,
        input bit re, input logic [31:0] epc,
        input bit rdv, input logic [31:0] dpc, input bit drdy,
        input bit e_rv, input logic [31:0] e_ra,
        input bit e_dv, input logic [31:0] e_pc, input logic [31:0] e_in);
        vec_t t;
        t.rdy = rdy; t.rv = rv; t.rd = rd;
        t.re = re; t.epc = epc; t.rdv = rdv; t.dpc = dpc;
        t.drdy = drdy; t.e_rv = e_rv; t.e_ra = e_ra;
        t.e_dv = e_dv; t.e_pc = e_pc; t.e_in = e_in;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        f.imem_req_ready = 1'b0;
        f.imem_rsp_valid = 1'b0;
        f.imem_rsp_data  = 32'h0;
        f.redir_e_valid  = 1'b0;
        f.redir_e_pc     = 32'h0;
        f.redir_d_valid  = 1'b0;
        f.redir_d_pc     = 32'h0;
        f.dec_ready      = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        chk("rst_req_valid", f.imem_req_valid, 0);
        chk("rst_req_addr", f.imem_req_addr, 0);
        chk("rst_dec_valid", f.dec_valid, 0);
        chk("rst_dec_pc_instr", {f.dec_pc, f.dec_instr}, 0);
        chk("rst_dec_pc_plus4", f.dec_pc_plus4, 0);
        @(negedge clk);
        mq.delete();
        sbq.delete();
        mpc      = 32'h0;
        epoch    = 0;
        last_due = -1;
        cyc      = 0;
        rst      = 1'b0;
    endtask

    // One cycle against the imem model and the decode scoreboard.
    task automatic step(input bit rdy, input bit drdy,
                        input bit re, input logic [31:0] epc,
                        input bit rd, input logic [31:0] dpc,
                        input int lat);
        memreq_t h;
        exp_t    e;
        bit      rv, fl;
        int      pre;
        rv = (mq.size() > 0) && (mq[0].due <= cyc);
        f.imem_rsp_valid = rv;
        f.imem_rsp_data  = 32'h0;
        if (rv) f.imem_rsp_data = mk(mq[0].addr);
        f.imem_req_ready = rdy;
        f.dec_ready      = drdy;
        f.redir_e_valid  = re;
        f.redir_e_pc     = epc;
        f.redir_d_valid  = rd;
        f.redir_d_pc     = dpc;
        #1;
        fl = re | rd;
        chk("req_valid", f.imem_req_valid,
            !fl && (sbq.size() + mq.size() < 4));
        chk("dec_valid", f.dec_valid, sbq.size() != 0);
        if (sbq.size() == 0) begin
            chk("dec_idle", {f.dec_pc, f.dec_instr}, 0);
            chk("dec_idle_p4", f.dec_pc_plus4, 0);
        end
        if (f.dec_valid === 1'b1 && first_dv < 0) first_dv = cyc;
        if (f.dec_valid === 1'b1 && drdy && !fl) n_dv_pop++;
        pre = sbq.size();
        if (pre != 0 && drdy && !fl) begin
            e = sbq.pop_front();
            chk("dec_pc", f.dec_pc, e.pc);
            chk("dec_instr", f.dec_instr, e.instr);
            chk("dec_pc_plus4", f.dec_pc_plus4, e.pc + 32'd4);
        end
        if (f.imem_req_valid === 1'b1 && rdy) begin
            chk("req_addr", f.imem_req_addr, mpc);
            h.addr  = f.imem_req_addr;
            h.epc   = mpc;
            h.due   = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            h.epoch = epoch;
            last_due = h.due;
            mq.push_back(h);
            mpc = mpc + 32'd4;
        end
        if (rv) begin
            h = mq.pop_front();
            if (!fl && h.epoch == epoch) begin
                chk("no_overflow", pre < 4, 1);
                e.instr = mk(h.epc);
                e.pc    = h.epc;
                sbq.push_back(e);
            end
        end
        if (fl) begin
            epoch++;
            sbq.delete();
            mpc = (re ? epc : dpc) & ~32'h3;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        int          base;
        logic [31:0] wa [$];
        logic [31:0] wp [$];
        logic [31:0] w4 [$];
        logic [31:0] wexp [3];
        logic [31:0] p4exp [3];
        logic [31:0] pa;
        bit          pv;

        tv[0]  = v(1,0,32'h0,         0,32'h0,  0,32'h0,  0, 1,32'h0,   0,32'h0,  32'h0);
        tv[1]  = v(1,0,32'h0,         0,32'h0,  0,32'h0,  0, 1,32'h4,   0,32'h0,  32'h0);
        tv[2]  = v(1,0,32'h0,         1,32'h100,0,32'h0,  0, 0,32'h0,   0,32'h0,  32'h0);
        tv[3]  = v(0,1,32'hDEAD_0000, 0,32'h0,  0,32'h0,  0, 1,32'h100, 0,32'h0,  32'h0);
        tv[4]  = v(1,1,32'hDEAD_0004, 0,32'h0,  0,32'h0,  0, 1,32'h100, 0,32'h0,  32'h0);
        tv[5]  = v(0,1,mk(32'h100),   0,32'h0,  0,32'h0,  0, 1,32'h104, 0,32'h0,  32'h0);
        tv[6]  = v(0,0,32'h0,         0,32'h0,  0,32'h0,  0, 1,32'h104, 1,32'h100,mk(32'h100));
        tv[7]  = v(1,0,32'h0,         1,32'h202,1,32'h301,1, 0,32'h0,   1,32'h100,mk(32'h100));
        tv[8]  = v(1,0,32'h0,         0,32'h0,  0,32'h0,  0, 1,32'h200, 0,32'h0,  32'h0);
        tv[9]  = v(1,0,32'h0,         0,32'h0,  1,32'h300,0, 0,32'h0,   0,32'h0,  32'h0);
        tv[10] = v(0,1,32'hDEAD_0200, 0,32'h0,  0,32'h0,  0, 1,32'h300, 0,32'h0,  32'h0);
        tv[11] = v(0,0,32'h0,         0,32'h0,  0,32'h0,  0, 1,32'h300, 0,32'h0,  32'h0);
        tv[12] = v(1,0,32'h0,         0,32'h0,  0,32'h0,  0, 1,32'h300, 0,32'h0,  32'h0);
        tv[13] = v(0,1,mk(32'h300),   0,32'h0,  0,32'h0,  0, 1,32'h304, 0,32'h0,  32'h0);
        tv[14] = v(0,0,32'h0,         0,32'h0,  0,32'h0,  1, 1,32'h304, 1,32'h300,mk(32'h300));
        tv[15] = v(1,0,32'h0,         0,32'h0,  0,32'h0,  1, 1,32'h304, 0,32'h0,  32'h0);
        tv[16] = v(0,1,32'hDEAD_0304, 1,32'h400,0,32'h0,  0, 0,32'h0,   0,32'h0,  32'h0);
        tv[17] = v(1,0,32'h0,         0,32'h0,  0,32'h0,  0, 1,32'h400, 0,32'h0,  32'h0);
        tv[18] = v(0,1,mk(32'h400),   0,32'h0,  0,32'h0,  0, 1,32'h404, 0,32'h0,  32'h0);
        tv[19] = v(0,0,32'h0,         0,32'h0,  0,32'h0,  0, 1,32'h404, 1,32'h400,mk(32'h400));

        idle();
        fw.imem_req_ready = 1'b0;
        fw.imem_rsp_valid = 1'b0;
        fw.imem_rsp_data  = 32'h0;
        fw.redir_e_valid  = 1'b0;
        fw.redir_e_pc     = 32'h0;
        fw.redir_d_valid  = 1'b0;
        fw.redir_d_pc     = 32'h0;
        fw.dec_ready      = 1'b0;
        first_dv = -1;
        n_dv_pop = 0;

        // Streaming at latency 1: first decode two cycles after first fetch.
        do_reset();
        first_dv = -1;
        base = n_dv_pop;
        repeat (20) step(1, 1, 0, 32'h0, 0, 32'h0, 1);
        chk("first_decode_cycle", first_dv, 2);
        chk("stream_decodes", n_dv_pop - base, 18);

        // Decode stall fills the queue and throttles requests.
        repeat (10) step(1, 0, 0, 32'h0, 0, 32'h0, 1);
        f.imem_rsp_valid = 1'b0;
        f.imem_req_ready = 1'b1;
        f.dec_ready      = 1'b0;
        #1;
        chk("stall_req_valid", f.imem_req_valid, 0);
        chk("stall_dec_valid", f.dec_valid, 1);
        base = n_dv_pop;
        repeat (4) step(1, 1, 0, 32'h0, 0, 32'h0, 1);
        chk("release_4", n_dv_pop - base, 4);
        repeat (8) step(1, 1, 0, 32'h0, 0, 32'h0, 1);

        // Hand-computed redirect/drop sequence.
        do_reset();
        for (int i = 0; i < NV; i++) begin
            f.imem_req_ready = tv[i].rdy;
            f.imem_rsp_valid = tv[i].rv;
            f.imem_rsp_data  = tv[i].rd;
            f.redir_e_valid  = tv[i].re;
            f.redir_e_pc     = tv[i].epc;
            f.redir_d_valid  = tv[i].rdv;
            f.redir_d_pc     = tv[i].dpc;
            f.dec_ready      = tv[i].drdy;
            #1;
            chk($sformatf("vec%0d_req_valid", i), f.imem_req_valid, tv[i].e_rv);
            if (tv[i].e_rv)
                chk($sformatf("vec%0d_req_addr", i), f.imem_req_addr, tv[i].e_ra);
            chk($sformatf("vec%0d_dec_valid", i), f.dec_valid, tv[i].e_dv);
            chk($sformatf("vec%0d_dec_pc", i), f.dec_pc, tv[i].e_pc);
            chk($sformatf("vec%0d_dec_instr", i), f.dec_instr, tv[i].e_in);
            chk($sformatf("vec%0d_dec_pc_plus4", i), f.dec_pc_plus4,
                tv[i].e_dv ? tv[i].e_pc + 32'd4 : 32'h0);
            @(posedge clk);
            @(negedge clk);
        end

        // Random latency, backpressure and redirects against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 99) < 4, $urandom,
                 $urandom_range(0, 99) < 4, $urandom,
                 $urandom_range(1, 3));
        end
        repeat (30) step(0, 1, 0, 32'h0, 0, 32'h0, 1);
        f.imem_rsp_valid = 1'b0;
        #1;
        chk("drain_empty", f.dec_valid, 0);

        // Address wrap from a reset PC near the top of memory.
        idle();
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_w = 1'b0;
        pv = 1'b0;
        pa = 32'h0;
        for (int c = 0; c < 8; c++) begin
            fw.imem_req_ready = (c < 3);
            fw.imem_rsp_valid = pv;
            fw.imem_rsp_data  = mk(pa);
            fw.dec_ready      = 1'b1;
            #1;
            if (fw.dec_valid === 1'b1) begin
                wp.push_back(fw.dec_pc);
                w4.push_back(fw.dec_pc_plus4);
            end
            pv = (fw.imem_req_valid === 1'b1) && fw.imem_req_ready;
            if (pv) begin
                pa = fw.imem_req_addr;
                wa.push_back(pa);
            end
            @(posedge clk);
            @(negedge clk);
        end
        wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFFC; wexp[2] = 32'h0;
        p4exp[0] = 32'hFFFF_FFFC; p4exp[1] = 32'h0; p4exp[2] = 32'h4;
        chk("wrap_n_req", wa.size(), 3);
        chk("wrap_n_dec", wp.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (k < wa.size()) chk($sformatf("wrap_addr%0d", k), wa[k], wexp[k]);
            if (k < wp.size()) chk($sformatf("wrap_pc%0d", k), wp[k], wexp[k]);
            if (k < w4.size()) chk($sformatf("wrap_p4_%0d", k), w4[k], p4exp[k]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
